// File: rtl/conv2d3x3_window_buffer_if.sv
// conv2d3x3_window_buffer_if: pixel-in / window-out bundle of the 3x3 window buffer
interface conv2d3x3_window_buffer_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 14
);
    logic                       In_Valid;
    logic [PIXEL_WIDTH-1:0]     In_Pixel;
    logic [9*PIXEL_WIDTH-1:0]   Win_Out;
    logic                       Win_Valid;
    logic                       Frame_Done;
    logic [CNT_WIDTH-1:0]       Col_Idx;
    logic [CNT_WIDTH-1:0]       Row_Idx;

    modport master (
        output In_Valid, In_Pixel,
        input  Win_Out, Win_Valid, Frame_Done, Col_Idx, Row_Idx
    );

    modport slave (
        input  In_Valid, In_Pixel,
        output Win_Out, Win_Valid, Frame_Done, Col_Idx, Row_Idx
    );
endinterface

// File: rtl/conv2d3x3_window_buffer.sv
// conv2d3x3_window_buffer: raster pixel stream to 3x3 sliding window with two line buffers
module conv2d3x3_window_buffer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_SIZE    = 100,
    parameter int CNT_WIDTH   = 14
) (
    input logic Clk,
    input logic Rst,
    conv2d3x3_window_buffer_if.slave bus
);
    localparam int AW = $clog2(IMG_SIZE);

    logic [PIXEL_WIDTH-1:0] lb0 [IMG_SIZE];
    logic [PIXEL_WIDTH-1:0] lb1 [IMG_SIZE];
    logic [PIXEL_WIDTH-1:0] win [9];
    logic [PIXEL_WIDTH-1:0] tap [3];
    logic [CNT_WIDTH-1:0]   col, row;
    logic [AW-1:0]          addr;
    logic                   col_last, row_last, win_vld, frm_done;

    assign addr     = col[AW-1:0];
    assign col_last = col == CNT_WIDTH'(IMG_SIZE - 1);
    assign row_last = row == CNT_WIDTH'(IMG_SIZE - 1);

    // column taps: two rows back, one row back, current pixel
    always_comb begin
        tap[0] = lb1[addr];
        tap[1] = lb0[addr];
        tap[2] = bus.In_Pixel;
    end

    // line buffers shift down one row per accept (read-before-write); contents are never reset
    always_ff @(posedge Clk) begin
        if (bus.In_Valid) begin
            lb1[addr] <= lb0[addr];
            lb0[addr] <= bus.In_Pixel;
        end
    end

    // window shifts left by one column per accept; the new right column comes from the taps
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
        end else if (bus.In_Valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r*3]   <= win[r*3+1];
                win[r*3+1] <= win[r*3+2];
                win[r*3+2] <= tap[r];
            end
        end
    end

    // raster position of the next pixel, plus the in-frame and end-of-frame flags of this accept
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col      <= '0;
            row      <= '0;
            win_vld  <= 1'b0;
            frm_done <= 1'b0;
        end else begin
            win_vld  <= bus.In_Valid && col >= CNT_WIDTH'(2) && row >= CNT_WIDTH'(2);
            frm_done <= bus.In_Valid && col_last && row_last;
            if (bus.In_Valid) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) row <= row_last ? '0 : row + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_out
        assign bus.Win_Out[k*PIXEL_WIDTH +: PIXEL_WIDTH] = win[k];
    end

    assign bus.Win_Valid  = win_vld;
    assign bus.Frame_Done = frm_done;
    assign bus.Col_Idx    = col;
    assign bus.Row_Idx    = row;
endmodule

// File: tb/tb_conv2d3x3_window_buffer.sv
// tb_conv2d3x3_window_buffer: scoreboard bench for the 3x3 window buffer on a 5x5 frame
module tb_conv2d3x3_window_buffer;
    localparam int N = 5;

    typedef struct {
        logic [71:0] w;
        int          cyc;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t        wq[$];
    int          fdq[$];
    logic [71:0] got[$];
    logic [71:0] ref_a[$];
    logic [7:0]  img [N][N];
    int          mr = 0;
    int          mc = 0;

    conv2d3x3_window_buffer_if #(.PIXEL_WIDTH(8), .CNT_WIDTH(14)) bus ();

    conv2d3x3_window_buffer #(.PIXEL_WIDTH(8), .IMG_SIZE(N), .CNT_WIDTH(14)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h at cycle %0d", n, a, e, cyc);
        end
    endtask

    // window whose top-left pixel is (r0,c0) of a frame with pixel = base + row*16 + col
    function automatic logic [71:0] pat(input int r0, input int c0, input int base);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(base + (r0 + k/3)*16 + c0 + k%3);
        return w;
    endfunction

    // reference: remember the frame, predict each in-frame window and frame end one cycle later
    task automatic send(input logic [7:0] p);
        exp_t e;
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            for (int k = 0; k < 9; k++) e.w[k*8 +: 8] = img[mr-2+k/3][mc-2+k%3];
            e.cyc = cyc + 1;
            wq.push_back(e);
        end
        if (mr == N-1 && mc == N-1) fdq.push_back(cyc + 1);
        mc = mc + 1;
        if (mc == N) begin
            mc = 0;
            mr = (mr + 1) % N;
        end
        bus.In_Valid = 1'b1;
        bus.In_Pixel = p;
        @(posedge Clk);
        #1;
        bus.In_Valid = 1'b0;
        bus.In_Pixel = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_frame(input int base, input int max_gap);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                send(8'(base + r*16 + c));
                if (max_gap > 0) idle($urandom_range(max_gap, 1));
            end
    endtask

    // monitor: pop expectations whenever the DUT flags a window or frame end
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                while (wq.size() > 0 && wq[0].cyc < cyc) begin
                    e = wq.pop_front();
                    chk("win_missing", 72'(cyc), 72'(e.cyc));
                end
                while (fdq.size() > 0 && fdq[0] < cyc) chk("fd_missing", 72'(cyc), 72'(fdq.pop_front()));
                if (bus.Win_Valid) begin
                    got.push_back(bus.Win_Out);
                    if (wq.size() == 0) chk("win_spurious", 72'(1), 72'(0));
                    else begin
                        e = wq.pop_front();
                        chk("win_cycle", 72'(cyc), 72'(e.cyc));
                        chk("win_data", bus.Win_Out, e.w);
                    end
                end
                if (bus.Frame_Done) begin
                    if (fdq.size() == 0) chk("fd_spurious", 72'(1), 72'(0));
                    else chk("fd_cycle", 72'(cyc), 72'(fdq.pop_front()));
                end
            end
        end
    end

    initial begin
        bus.In_Valid = 1'b0;
        bus.In_Pixel = '0;
        // reset held with In_Valid toggling
        for (int i = 0; i < 6; i++) begin
            bus.In_Valid = i[0];
            bus.In_Pixel = 8'($urandom);
            @(negedge Clk);
            chk("rst_win", bus.Win_Out, 72'(0));
            chk("rst_flags", {bus.Win_Valid, bus.Frame_Done}, 72'(0));
            chk("rst_idx", {bus.Row_Idx, bus.Col_Idx}, 72'(0));
        end
        bus.In_Valid = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        idle(1);

        // continuous pattern frame
        got.delete();
        send_frame(0, 0);
        idle(2);
        chk("a_count", 72'(got.size()), 72'(9));
        if (got.size() == 9) begin
            chk("a_first", got[0], pat(0, 0, 0));
            chk("a_rowwrap", got[3], pat(1, 0, 0));
            chk("a_last", got[8], pat(2, 2, 0));
        end
        chk("a_idx", {bus.Row_Idx, bus.Col_Idx}, 72'(0));
        ref_a = got;

        // same frame with 1-4 idle cycles after every pixel
        got.delete();
        send_frame(0, 4);
        idle(2);
        chk("gap_count", 72'(got.size()), 72'(ref_a.size()));
        if (got.size() == ref_a.size())
            for (int i = 0; i < got.size(); i++) chk("gap_same", got[i], ref_a[i]);

        // two back-to-back frames, second offset by 0x80
        got.delete();
        send_frame(0, 0);
        send_frame(8'h80, 0);
        idle(2);
        chk("b2b_count", 72'(got.size()), 72'(18));
        if (got.size() == 18) chk("b2b_first2", got[9], pat(0, 0, 8'h80));

        // random pixels with random gaps (including none)
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N*N; i++) begin
                send(8'($urandom));
                idle($urandom_range(3, 0));
            end
        idle(2);

        // reset after pixel 0x31, then a fresh frame
        for (int i = 0; i < 3*N + 2; i++) send(8'((i / N)*16 + i % N));
        chk("mid_idx", {bus.Row_Idx, bus.Col_Idx}, {14'd3, 14'd2});
        Rst = 1'b0;
        #1;
        chk("mid_rst_idx", {bus.Row_Idx, bus.Col_Idx}, 72'(0));
        chk("mid_rst_vld", {bus.Win_Valid, bus.Frame_Done}, 72'(0));
        mr = 0;
        mc = 0;
        got.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        send_frame(0, 0);
        idle(2);
        chk("post_rst_count", 72'(got.size()), 72'(9));
        if (got.size() > 0) chk("post_rst_first", got[0], pat(0, 0, 0));

        chk("wq_empty", 72'(wq.size()), 72'(0));
        chk("fdq_empty", 72'(fdq.size()), 72'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv2d3x3_window_buffer.md
Name: conv2d3x3_window_buffer

Overview:
- Upstream stage of the 3x3 convolution datapath. Converts a raster-order pixel stream into a 3x3 sliding window.
- Stores the two previous image rows in line buffers and keeps a 3x3 register window.
- Pulses Win_Valid only when all 9 window pixels lie inside the current frame.
- Tracks its own column and row position; emits a frame-done pulse after the last pixel.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- IMG_SIZE, 100, image width and height in pixels (square frame). Minimum 3.
- CNT_WIDTH, 14, width of the column and row counters. Must satisfy 2^CNT_WIDTH > IMG_SIZE.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset, asynchronous, active-low.
- In_Valid  input  1  pixel accept strobe; one pixel is consumed per cycle while high.
- In_Pixel  input  PIXEL_WIDTH  pixel data, raster order (row-major, left to right).
- Win_Out  output  9*PIXEL_WIDTH  registered window. Slice k=r*3+c is at [k*PIXEL_WIDTH +: PIXEL_WIDTH].
  - r=0 is the oldest (top) row; c=0 is the oldest (leftmost) column.
- Win_Valid  output  1  one-cycle pulse; Win_Out holds a complete in-frame window.
- Frame_Done  output  1  one-cycle pulse, one cycle after the last pixel of a frame is accepted.
- Col_Idx  output  CNT_WIDTH  column of the next pixel to be accepted, 0-based.
- Row_Idx  output  CNT_WIDTH  row of the next pixel to be accepted, 0-based.

Behaviour:
- Reset, asynchronous with Rst=0:
  - Col_Idx=0, Row_Idx=0.
  - All 9 window registers = 0, so Win_Out=0.
  - Win_Valid=0, Frame_Done=0.
  - Line buffer RAM contents are not reset; they are never exposed while Win_Valid=0.
- Line buffers: LB0 and LB1, IMG_SIZE entries each, addressed by Col_Idx.
- On an accept cycle (In_Valid=1) at column c:
  - Read taps: top = LB1[c], mid = LB0[c], bot = In_Pixel.
  - Writes: LB1[c] <= LB0[c]; LB0[c] <= In_Pixel. These are read-before-write in the same cycle.
  - Window shift: each row moves c0<=c1, c1<=c2, then c2 <= the new tap for that row.
- Window registers do not clear at row or frame boundaries. Invalid windows are suppressed by Win_Valid only.
- Counters on accept:
  - Col_Idx increments.
  - At Col_Idx=IMG_SIZE-1, Col_Idx wraps to 0 and Row_Idx increments.
  - At Row_Idx=IMG_SIZE-1 with Col_Idx=IMG_SIZE-1, both wrap to 0.
- Win_Valid is registered. It is 1 in the cycle after an accept whose pixel had column >= 2 and row >= 2; otherwise 0.
  - This gives exactly (IMG_SIZE-2)^2 pulses per frame.
- Frame_Done is registered. It is 1 in the cycle after accepting pixel (IMG_SIZE-1, IMG_SIZE-1); otherwise 0.
- Latency: 1 cycle from pixel accept to the matching Win_Out, Win_Valid and Frame_Done.
- In_Valid=0:
  - Counters, window and line buffers hold.
  - Win_Valid and Frame_Done return to 0 the next cycle.
  - Win_Out holds its last value.
- Back-to-back frames need no idle cycles. The first two rows of a new frame write old-frame data into the windows, but those windows are never flagged valid.
- Reset mid-frame: counters restart at (0,0). The next accepted pixel is treated as the first pixel of a new frame, and no Win_Valid pulse occurs until pixel (2,2) of that frame.
- No backpressure. The downstream stage must accept every Win_Valid pulse.

Test Plan:
Common setup: IMG_SIZE=5, PIXEL_WIDTH=8, frame pixel value = row*16+col (hex, e.g. 0x23 = row 2, col 3). Window values below are listed in slice order k=0..8.
- Reset: hold Rst=0 with In_Valid toggling -> Win_Out=0, Win_Valid=0, Frame_Done=0, Col_Idx=Row_Idx=0 throughout.
- Continuous 5x5 frame -> exactly 9 Win_Valid pulses.
  - First pulse one cycle after accepting pixel 0x22, with Win_Out = {00,01,02,10,11,12,20,21,22}.
  - Last pulse has Win_Out = {22,23,24,32,33,34,42,43,44}.
- Row wrap: after 0x24, accepting 0x30 and 0x31 -> no Win_Valid. Accepting 0x32 -> Win_Out = {10,11,12,20,21,22,30,31,32}.
- Random In_Valid gaps (1–4 idle cycles) -> identical sequence of 9 windows; Win_Valid never high on a cycle not preceded by an accept.
- Two back-to-back frames, second frame values offset by 0x80:
  - Frame_Done pulses once per frame, one cycle after 0x44 and after 0xC4.
  - No Win_Valid from the second frame's rows 0–1.
  - First window of the second frame = {80,81,82,90,91,92,A0,A1,A2}.
- Assert Rst for 1 cycle after accepting pixel 0x31, then stream a fresh frame -> Col_Idx=Row_Idx=0 immediately. Next Win_Valid occurs only after the fresh frame's pixel 0x22, with window {00,01,02,10,11,12,20,21,22}.
